// File: rtl/mc_nonarch_regs_pkg.sv
// Shared constants for the multi-cycle datapath register bank: opcodes, reset
// instruction and memory-address select encodings.
package mc_nonarch_regs_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic ADR_SRC_PC     = 1'b0;
  localparam logic ADR_SRC_RESULT = 1'b1;

endpackage

// File: rtl/mc_nonarch_regs_flopenr.sv
// Enable flop with an asynchronous active-high reset to a parameterised value.
module mc_nonarch_regs_flopenr #(
  parameter int unsigned        WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VAL;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mc_nonarch_regs.sv
// Non-architectural register bank of the multi-cycle RISC-V datapath:
// PC, OldPC, IR, memory data, A/B operands and ALUOut.
module mc_nonarch_regs
  import mc_nonarch_regs_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = INSTR_NOP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_update,
  input  logic             branch,
  input  logic             ir_write,
  input  logic             adr_src,
  input  logic             zero,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] old_pc,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] adr,
  output logic [6:0]       op,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic             pc_write,
  output logic             misaligned
);

  logic [WIDTH-1:0] pc_d;
  logic             misaligned_q;

  assign pc_write = pc_update | (branch & zero);
  // Low bits are dropped rather than trapped; the sticky flag records it.
  assign pc_d     = {result[WIDTH-1:2], 2'b00};
  assign adr      = (adr_src == ADR_SRC_RESULT) ? result : pc;

  mc_nonarch_regs_flopenr #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_write),
    .d     (pc_d),
    .q     (pc)
  );

  // Captures the pre-update pc, so a fetch with pc_write needs no ordering.
  mc_nonarch_regs_flopenr #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_old_pc (
    .clk   (clk),
    .reset (reset),
    .en    (ir_write),
    .d     (pc),
    .q     (old_pc)
  );

  mc_nonarch_regs_flopenr #(
    .WIDTH     (32),
    .RESET_VAL (NOP_INSTR)
  ) u_instr (
    .clk   (clk),
    .reset (reset),
    .en    (ir_write),
    .d     (mem_rdata[31:0]),
    .q     (instr)
  );

  mc_nonarch_regs_flopenr #(
    .WIDTH (WIDTH)
  ) u_data (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (mem_rdata),
    .q     (data)
  );

  mc_nonarch_regs_flopenr #(
    .WIDTH (WIDTH)
  ) u_a (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (rd1),
    .q     (a)
  );

  mc_nonarch_regs_flopenr #(
    .WIDTH (WIDTH)
  ) u_wdata (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (rd2),
    .q     (wdata)
  );

  mc_nonarch_regs_flopenr #(
    .WIDTH (WIDTH)
  ) u_alu_out (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (alu_result),
    .q     (alu_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else if (pc_write && (result[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end

  assign misaligned = misaligned_q;
  assign op         = instr[6:0];
  assign funct3     = instr[14:12];
  assign funct7b5   = instr[30];

endmodule

// File: tb/tb_mc_nonarch_regs.sv
// Directed self-checking bench for mc_nonarch_regs.
module tb_mc_nonarch_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_update, branch, ir_write, adr_src, zero;
  logic [31:0] result, mem_rdata, rd1, rd2, alu_result;
  logic [31:0] pc, old_pc, instr, data, a, wdata, alu_out, adr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, pc_write, misaligned;

  int errors = 0;
  int checks = 0;

  mc_nonarch_regs dut (
    .clk        (clk),
    .reset      (reset),
    .pc_update  (pc_update),
    .branch     (branch),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .zero       (zero),
    .result     (result),
    .mem_rdata  (mem_rdata),
    .rd1        (rd1),
    .rd2        (rd2),
    .alu_result (alu_result),
    .pc         (pc),
    .old_pc     (old_pc),
    .instr      (instr),
    .data       (data),
    .a          (a),
    .wdata      (wdata),
    .alu_out    (alu_out),
    .adr        (adr),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .pc_write   (pc_write),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; pc_update = 0; branch = 0; ir_write = 0; adr_src = 0; zero = 0;
    result = '0; mem_rdata = '0; rd1 = '0; rd2 = '0; alu_result = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_old_pc", old_pc, 32'h0);
    check("rst_instr", instr, 32'h13);
    check("rst_data", data, 32'h0);
    check("rst_a", a, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_alu_out", alu_out, 32'h0);
    check("rst_misaligned", {31'b0, misaligned}, 32'h0);

    // Load pc=0x40 and a non-NOP instruction, then reset mid-cycle.
    pc_update = 1; ir_write = 1; result = 32'h40; mem_rdata = 32'h0000_2083;
    step();
    pc_update = 0; ir_write = 0;
    check("pre_rst_pc", pc, 32'h40);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_instr", instr, 32'h13);
    check("async_rst_op", {25'b0, op}, 32'h13);
    reset = 1'b0;

    // Fetch: pc=8, load lw and advance pc to 0xC together.
    pc_update = 1; result = 32'h8;
    step();
    check("pc_8", pc, 32'h8);
    ir_write = 1; result = 32'hC; mem_rdata = 32'h0000_2083;
    #1;
    check("fetch_pc_write", {31'b0, pc_write}, 32'h1);
    step();
    pc_update = 0; ir_write = 0;
    check("fetch_instr", instr, 32'h2083);
    check("fetch_op", {25'b0, op}, 32'h03);
    check("fetch_funct3", {29'b0, funct3}, 32'h2);
    check("fetch_old_pc", old_pc, 32'h8);
    check("fetch_pc", pc, 32'hC);

    // Branch not taken, then taken.
    branch = 1; zero = 0; result = 32'h20;
    #1;
    check("bnt_pc_write", {31'b0, pc_write}, 32'h0);
    step();
    check("bnt_pc", pc, 32'hC);
    zero = 1;
    #1;
    check("bt_pc_write", {31'b0, pc_write}, 32'h1);
    step();
    check("bt_pc", pc, 32'h20);

    // pc_update with branch overrides zero=0.
    zero = 0; pc_update = 1; result = 32'h10;
    #1;
    check("both_pc_write", {31'b0, pc_write}, 32'h1);
    step();
    branch = 0; pc_update = 0;
    check("both_pc", pc, 32'h10);

    // Address mux, combinational.
    result = 32'h100; adr_src = 0;
    #1;
    check("adr_pc", adr, 32'h10);
    adr_src = 1;
    #1;
    check("adr_result", adr, 32'h100);
    adr_src = 0;

    // Free-running registers: one edge of latency.
    rd1 = 32'd5; rd2 = 32'd7; alu_result = 32'd12; mem_rdata = 32'hDEAD;
    #1;
    check("pipe_a_before", a, 32'h0);
    step();
    check("pipe_a", a, 32'd5);
    check("pipe_wdata", wdata, 32'd7);
    check("pipe_alu_out", alu_out, 32'd12);
    check("pipe_data", data, 32'hDEAD);
    check("pipe_instr_hold", instr, 32'h2083);
    rd1 = 32'hA5A5_0001; rd2 = 32'h0; alu_result = 32'hFFFF_FFFF; mem_rdata = 32'h4000_0033;
    step();
    check("pipe2_a", a, 32'hA5A5_0001);
    check("pipe2_alu_out", alu_out, 32'hFFFF_FFFF);
    check("pipe2_data", data, 32'h4000_0033);

    // IR load of sub: funct7b5 set, old_pc captures current pc.
    ir_write = 1;
    step();
    ir_write = 0;
    check("sub_op", {25'b0, op}, 32'h33);
    check("sub_funct7b5", {31'b0, funct7b5}, 32'h1);
    check("sub_funct3", {29'b0, funct3}, 32'h0);
    check("sub_old_pc", old_pc, 32'h10);

    // Top-of-space target loads unchanged.
    pc_update = 1; result = 32'hFFFF_FFFC;
    step();
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_misaligned", {31'b0, misaligned}, 32'h0);

    // Misaligned target is truncated and the flag sticks.
    result = 32'h22;
    step();
    check("mis_pc", pc, 32'h20);
    check("mis_flag", {31'b0, misaligned}, 32'h1);
    result = 32'h40;
    step();
    check("mis_sticky_pc", pc, 32'h40);
    check("mis_sticky_flag", {31'b0, misaligned}, 32'h1);
    pc_update = 0;
    step();
    check("mis_sticky_idle", {31'b0, misaligned}, 32'h1);
    reset = 1'b1;
    #1;
    check("mis_cleared", {31'b0, misaligned}, 32'h0);
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_nonarch_regs.md
Name: mc_nonarch_regs

Overview:
- Non-architectural register bank of the multi-cycle RISC-V datapath: PC, OldPC, instruction register, memory-data register, A/B operand registers and ALUOut.
- Sits between memory, register file, ALU and main_fsm.
- Consumes main_fsm control outputs (pc_update, branch, ir_write, adr_src) and produces the op/funct fields main_fsm and the ALU decoder decode next.

Parameters:
- WIDTH, 32, datapath width in bits.
- RESET_PC, 32'h0000_0000, PC value after reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, instruction register value after reset (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_update  input  1  unconditional PC write request from main_fsm.
- branch  input  1  conditional PC write request from main_fsm.
- ir_write  input  1  load instruction register and OldPC.
- adr_src  input  1  memory address select: 0 = pc, 1 = result.
- zero  input  1  ALU zero flag.
- result  input  WIDTH  result-mux output; next PC and data address.
- mem_rdata  input  WIDTH  memory read data.
- rd1  input  WIDTH  register file read port 1.
- rd2  input  WIDTH  register file read port 2.
- alu_result  input  WIDTH  ALU combinational output.
- pc  output  WIDTH  current PC.
- old_pc  output  WIDTH  PC of the instruction held in instr.
- instr  output  32  instruction register.
- data  output  WIDTH  registered memory read data.
- a  output  WIDTH  registered rd1.
- wdata  output  WIDTH  registered rd2; store data and ALU operand.
- alu_out  output  WIDTH  registered alu_result.
- adr  output  WIDTH  memory address.
- op  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7b5  output  1  instr[30].
- pc_write  output  1  effective PC write enable.
- misaligned  output  1  sticky flag for a misaligned PC target.

Behaviour:
- Reset (asynchronous, applies immediately, including mid-instruction):
  - pc = RESET_PC; old_pc = RESET_PC; instr = NOP_INSTR.
  - data, a, wdata, alu_out = 0; misaligned = 0.
- Combinational outputs (no latency):
  - pc_write = pc_update | (branch & zero).
  - adr = adr_src ? result : pc.
  - op, funct3, funct7b5 are pure slices of instr.
- PC: on pc_write, pc <= {result[WIDTH-1:2], 2'b00}. Otherwise pc holds.
- Misaligned flag: on pc_write with result[1:0] != 0, misaligned <= 1. It stays set until reset.
- Instruction load: on ir_write, instr <= mem_rdata and old_pc <= pc. Both are updated in the same cycle.
- Simultaneous ir_write and pc_write (fetch cycle): old_pc captures the pre-update pc and pc takes the new value. No ordering hazard.
- data, a, wdata, alu_out load every cycle with no enable. Each presents its input with exactly one cycle of latency.
- branch=1 with zero=0: pc_write=0 and pc holds.
- pc_update and branch both high: pc_write=1 regardless of zero.
- Wrap-around: a result of 32'hFFFF_FFFC loads unchanged. The block does no address arithmetic, so it never overflows.
- No internal FSM. Sequencing is owned entirely by main_fsm; this block only obeys its enables.

Decomposition:
- Shared package holds:
  - opcode constants: OP_LW 7'b0000011, OP_SW 7'b0100011, OP_R 7'b0110011, OP_I 7'b0010011, OP_JAL 7'b1101111, OP_BEQ 7'b1100011.
  - the NOP_INSTR constant.
  - the adr_src encodings.
- One sub-module is natural: flopenr (WIDTH-parameterised enable flop with asynchronous reset value). It is instantiated for pc, old_pc and instr; the free-running registers use it with en tied to 1.

Test Plan:
- Reset: assert reset mid-cycle with pc=32'h40. Expect pc=0, instr=32'h13 and op=7'b0010011 immediately, without waiting for a clock edge.
- Fetch: pc=32'h8, mem_rdata=32'h0000_2083 (lw), ir_write=1, pc_update=1, result=32'hC. After the edge expect instr=32'h2083, op=7'b0000011, old_pc=32'h8, pc=32'hC.
- Branch: branch=1. With zero=0 expect pc_write=0 and pc unchanged. With zero=1 and result=32'h20 expect pc=32'h20 next cycle.
- Address mux: pc=32'h10, result=32'h100. Expect adr=32'h10 with adr_src=0 and adr=32'h100 with adr_src=1, in the same cycle.
- Pipeline registers: drive rd1=5, rd2=7, alu_result=12, mem_rdata=32'hDEAD. Expect a=5, wdata=7, alu_out=12, data=32'hDEAD exactly one edge later.
- Misaligned: pc_update=1, result=32'h22. Expect pc=32'h20 and misaligned=1, and the flag stays 1 after later aligned jumps until reset.
